// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for spi_cs_sequencer (optional RX FIFO via SPI_CS_RX_FIFO_EN).
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, ISSUE, WAIT_RX, WAIT_HOST, CS_INACTIVE} spi_cs_state_t;
  localparam int SPI_RX_FIFO_DEPTH = 4;
  function automatic int clamp_count(input int count, input int max_count);
    return count == 0 ? 1 : (count > max_count ? max_count : count);
  endfunction
endpackage

// File: rtl/spi_cs_sequencer_if.sv
// spi_cs_sequencer_if: host and SPI-master handshake bundle; SPI_CS_RX_FIFO_EN adds RX back-pressure and overflow.
interface spi_cs_sequencer_if #(parameter int MAX_BYTES_PER_CS = 2);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  logic [CW-1:0] i_TX_Count, o_RX_Count;
  logic [7:0] i_TX_Byte, o_RX_Byte, o_M_TX_Byte, i_M_RX_Byte;
  logic i_TX_Valid, o_TX_Ready, o_RX_Valid, o_M_TX_Valid, i_M_TX_Ready, i_M_RX_Valid;
`ifdef SPI_CS_RX_FIFO_EN
  logic i_RX_Ready, o_RX_Overflow;
`endif
  modport slave (
    input i_TX_Count, i_TX_Byte, i_TX_Valid, i_M_TX_Ready, i_M_RX_Valid, i_M_RX_Byte,
`ifdef SPI_CS_RX_FIFO_EN
    input i_RX_Ready, output o_RX_Overflow,
`endif
    output o_TX_Ready, o_RX_Count, o_RX_Valid, o_RX_Byte, o_M_TX_Byte, o_M_TX_Valid
  );
  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_Valid, i_M_TX_Ready, i_M_RX_Valid, i_M_RX_Byte,
`ifdef SPI_CS_RX_FIFO_EN
    output i_RX_Ready, input o_RX_Overflow,
`endif
    input o_TX_Ready, o_RX_Count, o_RX_Valid, o_RX_Byte, o_M_TX_Byte, o_M_TX_Valid
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: small synchronous FIFO with sticky overflow, used by spi_cs_sequencer under SPI_CS_RX_FIFO_EN.
module spi_rx_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         overflow
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push && (cnt != (AW+1)'(DEPTH) || do_pop);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
endmodule

// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer: multi-byte transaction front end owning SPI chip select; SPI_CS_RX_FIFO_EN buffers RX bytes in a FIFO.
module spi_cs_sequencer
  import spi_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  spi_cs_sequencer_if.slave    bus,
  output logic                 o_SPI_CS_n
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int IW = CS_INACTIVE_CLKS > 1 ? $clog2(CS_INACTIVE_CLKS) : 1;
  spi_cs_state_t state;
  logic [CW-1:0] remaining, rx_idx, rx_count;
  logic [IW-1:0] gap;
  logic [7:0] m_tx_byte, rx_byte;
  logic tx_ready, m_tx_valid, rx_valid, cs_n, got_rx;
  always_ff @(posedge i_Clk)
    if (!i_Rst_L) begin
      state <= IDLE;
      cs_n <= 1'b1;
      tx_ready <= 1'b0;
      m_tx_valid <= 1'b0;
      m_tx_byte <= '0;
      rx_valid <= 1'b0;
      rx_byte <= '0;
      rx_count <= '0;
      rx_idx <= '0;
      remaining <= '0;
      gap <= '0;
      got_rx <= 1'b0;
    end else begin
      m_tx_valid <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= bus.i_M_TX_Ready;
          if (bus.i_TX_Valid && tx_ready) begin
            tx_ready <= 1'b0;
            m_tx_byte <= bus.i_TX_Byte;
            remaining <= CW'(clamp_count(int'(bus.i_TX_Count), MAX_BYTES_PER_CS));
            rx_idx <= '0;
            cs_n <= 1'b0;
            state <= CS_SETUP;
          end
        end
        CS_SETUP: state <= ISSUE;
        ISSUE: begin
          m_tx_valid <= 1'b1;
          remaining <= remaining - 1'b1;
          got_rx <= 1'b0;
          state <= WAIT_RX;
        end
        WAIT_RX: begin
          if (!got_rx && bus.i_M_RX_Valid) begin
            rx_valid <= 1'b1;
            rx_byte <= bus.i_M_RX_Byte;
            rx_count <= rx_idx;
            rx_idx <= rx_idx + 1'b1;
            got_rx <= 1'b1;
          end
          // master ready lags its busy state by a cycle, so only trust it once the byte has returned
          if (got_rx && bus.i_M_TX_Ready) begin
            if (remaining == '0) begin
              cs_n <= 1'b1;
              gap <= '0;
              state <= CS_INACTIVE;
            end else begin
              tx_ready <= 1'b1;
              state <= WAIT_HOST;
            end
          end
        end
        WAIT_HOST:
          if (bus.i_TX_Valid) begin
            tx_ready <= 1'b0;
            m_tx_byte <= bus.i_TX_Byte;
            state <= ISSUE;
          end
        CS_INACTIVE:
          if (gap == IW'(CS_INACTIVE_CLKS - 1)) begin
            tx_ready <= bus.i_M_TX_Ready;
            state <= IDLE;
          end else gap <= gap + 1'b1;
        default: state <= IDLE;
      endcase
    end
  assign o_SPI_CS_n = cs_n;
  assign bus.o_TX_Ready = tx_ready;
  assign bus.o_M_TX_Valid = m_tx_valid;
  assign bus.o_M_TX_Byte = m_tx_byte;
`ifdef SPI_CS_RX_FIFO_EN
  logic empty;
  logic [CW+7:0] head;
  spi_rx_fifo #(.W(CW + 8), .DEPTH(SPI_RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(i_Clk),
    .rst_n(i_Rst_L),
    .push(rx_valid),
    .pop(!empty && bus.i_RX_Ready),
    .din({rx_count, rx_byte}),
    .dout(head),
    .empty(empty),
    .overflow(bus.o_RX_Overflow)
  );
  assign bus.o_RX_Valid = !empty;
  assign {bus.o_RX_Count, bus.o_RX_Byte} = head;
`else
  assign bus.o_RX_Valid = rx_valid;
  assign bus.o_RX_Byte = rx_byte;
  assign bus.o_RX_Count = rx_count;
`endif
endmodule

// File: tb/tb_spi_cs_sequencer.sv
// tb_spi_cs_sequencer: self-checking bench with loopback SPI master model; covers SPI_CS_RX_FIFO_EN when defined.
module tb_spi_cs_sequencer;
  localparam int MAXB = 2;
  localparam int GAP = 1;
  localparam int CW = $clog2(MAXB + 1);
  typedef struct {
    int cnt;
    logic [7:0] b0;
    logic [7:0] b1;
    int late;
    int exp_n;
    int exp_hi;
  } vec_t;
  typedef struct {
    logic [7:0] b;
    int idx;
  } rx_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n;
  int compared = 0, mismatched = 0;
  int tx_seen = 0, rx_seen = 0, falls = 0, rises = 0, hi = 0, last_hi = -1;
  bit prev_cs = 1'b1, measuring = 1'b0;
  bit busy = 1'b0, outstanding = 1'b0;
  int lat = 0, m_lat_lo = 0, m_lat_hi = 4;
  logic [7:0] sh;
  rx_t exp_q[$];
  logic [7:0] txq[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  spi_cs_sequencer_if #(.MAX_BYTES_PER_CS(MAXB)) bus ();
  spi_cs_sequencer #(.MAX_BYTES_PER_CS(MAXB), .CS_INACTIVE_CLKS(GAP)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus), .o_SPI_CS_n(cs_n)
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // loopback master: ready drops one cycle after accepting, returns with the RX pulse
  always @(negedge clk) begin
    if (bus.i_M_RX_Valid || !rst_n) outstanding = 1'b0;
    bus.i_M_RX_Valid = 1'b0;
    if (bus.o_M_TX_Valid) begin
      check("tx_twice_without_rx", int'(outstanding), 0);
      outstanding = 1'b1;
    end
    if (busy) begin
      bus.i_M_TX_Ready = 1'b0;
      if (lat == 0) begin
        bus.i_M_RX_Valid = 1'b1;
        bus.i_M_RX_Byte = sh;
        busy = 1'b0;
        bus.i_M_TX_Ready = 1'b1;
      end else lat--;
    end else begin
      bus.i_M_TX_Ready = 1'b1;
      if (bus.o_M_TX_Valid) begin
        busy = 1'b1;
        sh = bus.o_M_TX_Byte;
        lat = $urandom_range(m_lat_hi, m_lat_lo);
      end
    end
  end

  always @(negedge clk) begin
    rx_t e;
    bit fire;
    #1;
`ifdef SPI_CS_RX_FIFO_EN
    fire = bus.o_RX_Valid && bus.i_RX_Ready;
`else
    fire = bus.o_RX_Valid;
`endif
    if (fire) begin
      rx_seen++;
      if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rx_byte", int'(bus.o_RX_Byte), int'(e.b));
        check("rx_index", int'(bus.o_RX_Count), e.idx);
      end
    end
    if (bus.o_M_TX_Valid) begin
      tx_seen++;
      if (txq.size() == 0) check("tx_unexpected", 1, 0);
      else check("tx_byte", int'(bus.o_M_TX_Byte), int'(txq.pop_front()));
      check("cs_low_at_tx", int'(cs_n), 0);
    end
    if (prev_cs && !cs_n) falls++;
    if (!prev_cs && cs_n) begin
      rises++;
      hi = 0;
      measuring = 1'b1;
    end
    if (measuring) begin
      if (bus.o_TX_Ready) begin
        last_hi = hi;
        measuring = 1'b0;
      end else if (cs_n) hi++;
    end
    prev_cs = cs_n;
  end

  task automatic send_byte(input logic [7:0] b, input int cnt, input int idx);
    int w = 0;
    while (!bus.o_TX_Ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.o_TX_Ready) begin
      check("tx_ready_timeout", 0, 1);
      return;
    end
    bus.i_TX_Byte = b;
    bus.i_TX_Count = CW'(cnt);
    bus.i_TX_Valid = 1'b1;
    txq.push_back(b);
    exp_q.push_back('{b, idx});
    @(negedge clk);
    bus.i_TX_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(cs_n && bus.o_TX_Ready && !busy) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cs_n"}, int'(cs_n), 1);
    check({tag, "_tx_ready"}, int'(bus.o_TX_Ready), 0);
    check({tag, "_m_tx_valid"}, int'(bus.o_M_TX_Valid), 0);
    check({tag, "_rx_valid"}, int'(bus.o_RX_Valid), 0);
    check({tag, "_rx_count"}, int'(bus.o_RX_Count), 0);
    check({tag, "_m_tx_byte"}, int'(bus.o_M_TX_Byte), 0);
    check({tag, "_rx_byte"}, int'(bus.o_RX_Byte), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, f0, q0, n, c;
    bus.i_TX_Valid = 1'b0;
    bus.i_TX_Byte = '0;
    bus.i_TX_Count = '0;
`ifdef SPI_CS_RX_FIFO_EN
    bus.i_RX_Ready = 1'b1;
`endif
    vecs[0] = '{1, 8'hA5, 8'h00, 0, 1, GAP};
    vecs[1] = '{2, 8'h3C, 8'hC3, 20, 2, GAP};
    vecs[2] = '{0, 8'h11, 8'h00, 0, 1, GAP};
    vecs[3] = '{7, 8'h5A, 8'h96, 0, 2, GAP};
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      t0 = tx_seen; r0 = rx_seen; f0 = falls; q0 = rises;
      send_byte(vecs[i].b0, vecs[i].cnt, 0);
      if (vecs[i].exp_n > 1) begin
        repeat (vecs[i].late) @(negedge clk);
        send_byte(vecs[i].b1, vecs[i].cnt, 1);
      end
      wait_idle();
      check($sformatf("vec%0d_tx_pulses", i), tx_seen - t0, vecs[i].exp_n);
      check($sformatf("vec%0d_rx_pulses", i), rx_seen - r0, vecs[i].exp_n);
      check($sformatf("vec%0d_cs_falls", i), falls - f0, 1);
      check($sformatf("vec%0d_cs_rises", i), rises - q0, 1);
      check($sformatf("vec%0d_cs_high_gap", i), last_hi, vecs[i].exp_hi);
    end
    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(3, 0);
      n = c == 0 ? 1 : (c > MAXB ? MAXB : c);
      m_lat_lo = 0;
      m_lat_hi = $urandom_range(4, 0);
      t0 = tx_seen; f0 = falls;
      for (int k = 0; k < n; k++) begin
        if (k > 0) repeat ($urandom_range(5, 0)) @(negedge clk);
        send_byte(8'($urandom), c, k);
      end
      wait_idle();
      check("rand_tx_pulses", tx_seen - t0, n);
      check("rand_cs_falls", falls - f0, 1);
      check("rand_cs_high_gap", last_hi, GAP);
      check("rand_rx_drained", exp_q.size(), 0);
    end
    m_lat_lo = 10;
    m_lat_hi = 10;
    send_byte(8'h77, 1, 0);
    n = 0;
    while (!bus.o_M_TX_Valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_tx_issued", int'(bus.o_M_TX_Valid), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst_wait_rx");
    exp_q.delete();
    txq.delete();
    rst_n = 1'b1;
    r0 = rx_seen;
    repeat (15) @(negedge clk);
    check("rst_late_rx_ignored", rx_seen - r0, 0);
    check("rst_cs_stays_high", int'(cs_n), 1);
    check("rst_tx_ready_back", int'(bus.o_TX_Ready), 1);
`ifdef SPI_CS_RX_FIFO_EN
    m_lat_lo = 0;
    m_lat_hi = 2;
    bus.i_RX_Ready = 1'b0;
    r0 = rx_seen;
    for (int t = 0; t < 3; t++) begin
      send_byte(8'h10 + 8'(2 * t), 2, 0);
      send_byte(8'h11 + 8'(2 * t), 2, 1);
      wait_idle();
      if (t == 1) check("fifo_no_overflow_when_full", int'(bus.o_RX_Overflow), 0);
    end
    check("fifo_overflow_set", int'(bus.o_RX_Overflow), 1);
    check("fifo_held", rx_seen - r0, 0);
    check("fifo_valid_while_held", int'(bus.o_RX_Valid), 1);
    bus.i_RX_Ready = 1'b1;
    repeat (8) @(negedge clk);
    check("fifo_drained_count", rx_seen - r0, 4);
    check("fifo_dropped", exp_q.size(), 2);
    check("fifo_empty_after_drain", int'(bus.o_RX_Valid), 0);
    exp_q.delete();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
